// File: rtl/ascon_pkg.sv
// Shared types and helpers for the ASCON-128 AEAD control path: FSM encoding
// (exported on state_o), default round counts and the round-constant mapping.
package ascon_pkg;

  localparam int PA_ROUNDS_DEF = 12;
  localparam int PB_ROUNDS_DEF = 6;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT_LOAD  = 4'd1,
    ST_INIT_PERM  = 4'd2,
    ST_INIT_KEY   = 4'd3,
    ST_AD_WAIT    = 4'd4,
    ST_AD_PERM    = 4'd5,
    ST_DSEP       = 4'd6,
    ST_MSG_WAIT   = 4'd7,
    ST_MSG_OUT    = 4'd8,
    ST_MSG_PERM   = 4'd9,
    ST_FINAL_KEY  = 4'd10,
    ST_FINAL_PERM = 4'd11,
    ST_TAG        = 4'd12,
    ST_DONE       = 4'd13
  } state_e;

  // Round constant for absolute round index i: high nibble 15-i, low nibble i.
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic is_perm(input state_e s);
    return (s == ST_INIT_PERM) || (s == ST_AD_PERM) ||
           (s == ST_MSG_PERM)  || (s == ST_FINAL_PERM);
  endfunction

endpackage

// File: rtl/ascon_round_sched.sv
// Permutation round scheduler: a load starts a run of nr rounds whose indices
// climb from MAX_ROUNDS-nr to MAX_ROUNDS-1, emitting enable, constant and last.
module ascon_round_sched
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] nr_i,
  output logic       round_en_o,
  output logic [7:0] round_const_o,
  output logic       last_round_o
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS - 1);

  logic       active_q, active_d;
  logic [3:0] idx_q, idx_d;

  // Every run, long or short, ends on the same index, so "last" needs no length.
  assign last_round_o  = active_q && (idx_q == LAST_IDX);
  assign round_en_o    = active_q;
  assign round_const_o = active_q ? rc(idx_q) : 8'h00;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    if (clear_i) begin
      active_d = 1'b0;
      idx_d    = 4'd0;
    end else if (load_i) begin
      active_d = 1'b1;
      idx_d    = 4'(MAX_ROUNDS) - nr_i;
    end else if (active_q) begin
      if (last_round_o) begin
        active_d = 1'b0;
        idx_d    = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= 4'd0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/ascon_aead_ctrl.sv
// ASCON-128 AEAD sequencing FSM: converts a start command and block counts into
// datapath strobes and moves AD/message/output/tag blocks over handshakes.
module ascon_aead_ctrl
  import ascon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PA_ROUNDS = PA_ROUNDS_DEF,
  parameter int PB_ROUNDS = PB_ROUNDS_DEF
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             decrypt_i,
  input  logic [CNT_W-1:0] ad_blocks_i,
  input  logic [CNT_W-1:0] msg_blocks_i,
  input  logic             ad_valid_i,
  output logic             ad_ready_o,
  input  logic             msg_valid_i,
  output logic             msg_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             tag_valid_o,
  input  logic             tag_ready_i,
  output logic             dp_init_o,
  output logic             dp_round_en_o,
  output logic [7:0]       dp_round_const_o,
  output logic             dp_absorb_ad_o,
  output logic             dp_absorb_msg_o,
  output logic             dp_key_xor_o,
  output logic             dp_dsep_o,
  output logic             dp_decrypt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic             decrypt_q, decrypt_d;
  logic             sched_load;
  logic [3:0]       sched_nr;
  logic             last_round;

  // A run is armed on the edge into a permutation state, so rounds line up with it.
  assign sched_load = is_perm(state_d) && !is_perm(state_q);
  assign sched_nr   = ((state_d == ST_INIT_PERM) || (state_d == ST_FINAL_PERM)) ?
                      4'(PA_ROUNDS) : 4'(PB_ROUNDS);

  ascon_round_sched #(
    .MAX_ROUNDS (PA_ROUNDS)
  ) u_sched (
    .clk           (S_AXI_ACLK),
    .rst_n         (S_AXI_ARESETN),
    .clear_i       (clear_i),
    .load_i        (sched_load),
    .nr_i          (sched_nr),
    .round_en_o    (dp_round_en_o),
    .round_const_o (dp_round_const_o),
    .last_round_o  (last_round)
  );

  assign ad_ready_o      = (state_q == ST_AD_WAIT);
  assign msg_ready_o     = (state_q == ST_MSG_WAIT);
  assign out_valid_o     = (state_q == ST_MSG_OUT);
  assign tag_valid_o     = (state_q == ST_TAG);
  assign dp_init_o       = (state_q == ST_INIT_LOAD);
  assign dp_key_xor_o    = (state_q == ST_INIT_KEY) || (state_q == ST_FINAL_KEY);
  assign dp_dsep_o       = (state_q == ST_DSEP);
  assign dp_absorb_ad_o  = ad_ready_o && ad_valid_i;
  assign dp_absorb_msg_o = msg_ready_o && msg_valid_i;
  assign dp_decrypt_o    = decrypt_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign state_o         = state_q;

  always_comb begin
    state_d   = state_q;
    ad_cnt_d  = ad_cnt_q;
    msg_cnt_d = msg_cnt_q;
    decrypt_d = decrypt_q;
    if (clear_i) begin
      state_d   = ST_IDLE;
      ad_cnt_d  = '0;
      msg_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          ad_cnt_d  = ad_blocks_i;
          msg_cnt_d = (msg_blocks_i == '0) ? CNT_W'(1) : msg_blocks_i;
          decrypt_d = decrypt_i;
          state_d   = ST_INIT_LOAD;
        end
        ST_INIT_LOAD: state_d = ST_INIT_PERM;
        ST_INIT_PERM: if (last_round) state_d = ST_INIT_KEY;
        ST_INIT_KEY:  state_d = (ad_cnt_q != '0) ? ST_AD_WAIT : ST_DSEP;
        ST_AD_WAIT:   if (ad_valid_i) state_d = ST_AD_PERM;
        ST_AD_PERM: if (last_round) begin
          ad_cnt_d = ad_cnt_q - CNT_W'(1);
          state_d  = (ad_cnt_q > CNT_W'(1)) ? ST_AD_WAIT : ST_DSEP;
        end
        ST_DSEP:     state_d = ST_MSG_WAIT;
        ST_MSG_WAIT: if (msg_valid_i) state_d = ST_MSG_OUT;
        ST_MSG_OUT: if (out_ready_i) begin
          state_d = (msg_cnt_q > CNT_W'(1)) ? ST_MSG_PERM : ST_FINAL_KEY;
        end
        ST_MSG_PERM: if (last_round) begin
          msg_cnt_d = msg_cnt_q - CNT_W'(1);
          state_d   = ST_MSG_WAIT;
        end
        ST_FINAL_KEY:  state_d = ST_FINAL_PERM;
        ST_FINAL_PERM: if (last_round) state_d = ST_TAG;
        ST_TAG:        if (tag_ready_i) state_d = ST_DONE;
        ST_DONE:       state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      ad_cnt_q  <= '0;
      msg_cnt_q <= '0;
      decrypt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ad_cnt_q  <= ad_cnt_d;
      msg_cnt_q <= msg_cnt_d;
      decrypt_q <= decrypt_d;
    end
  end

endmodule

// File: doc/ascon_aead_ctrl.md
Name: ascon_aead_ctrl

Overview:
- Sequencing FSM for the ASCON-128 AEAD datapath behind the ascon_core AXI-lite register bank.
- Turns a start command plus block counts into datapath strobes: init load, 12/6-round permutation runs with round constants, AD/message absorb, domain separation, key XORs and tag release.
- Moves AD, message and output blocks over valid/ready handshakes.
- Sits between the register file (command, status) and the 320-bit state/round datapath, which it never touches directly.

Parameters:
- CNT_W, 16, width of block-count inputs and internal block counters.
- PA_ROUNDS, 12, rounds for init and final permutations.
- PB_ROUNDS, 6, rounds for intermediate permutations.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- start_i  in  1  begin operation; sampled only in IDLE.
- clear_i  in  1  synchronous abort to IDLE from any state.
- decrypt_i  in  1  mode, latched at start; forwarded as dp_decrypt_o.
- ad_blocks_i  in  CNT_W  AD blocks including padded block; 0 = no AD.
- msg_blocks_i  in  CNT_W  message blocks including final padded block; 0 is treated as 1.
- ad_valid_i / ad_ready_o  in/out  1  AD block handshake.
- msg_valid_i / msg_ready_o  in/out  1  message block handshake.
- out_valid_o / out_ready_i  out/in  1  ciphertext/plaintext block handshake.
- tag_valid_o / tag_ready_i  out/in  1  tag handshake.
- dp_init_o  out  1  load IV||K||N into state.
- dp_round_en_o  out  1  apply one round this cycle.
- dp_round_const_o  out  8  round constant.
- dp_absorb_ad_o, dp_absorb_msg_o  out  1  XOR block into rate.
- dp_key_xor_o  out  1  XOR key into capacity (init tail / final head).
- dp_dsep_o  out  1  XOR 1 into state LSB.
- dp_decrypt_o  out  1  latched mode.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  single-cycle completion pulse.
- state_o  out  4  FSM encoding for status readback.

Behaviour:
- Reset (async, ARESETN low): state IDLE. All outputs 0, counters 0, dp_round_const_o 0.
- The FSM is fully registered. dp_absorb_* is combinational with its handshake (valid && ready). All other outputs decode from state.
- States and transitions:
  - IDLE: on start_i, latch counts and decrypt_i -> INIT_LOAD. start_i in any other state is ignored.
  - INIT_LOAD: dp_init_o=1 for 1 cycle -> INIT_PERM.
  - INIT_PERM: PA_ROUNDS cycles with dp_round_en_o=1 -> INIT_KEY.
  - INIT_KEY: dp_key_xor_o=1 for 1 cycle -> AD_WAIT if ad_blocks != 0, else DSEP.
  - AD_WAIT: ad_ready_o=1. On handshake, dp_absorb_ad_o=1 -> AD_PERM.
  - AD_PERM: PB_ROUNDS rounds, then decrement AD counter -> AD_WAIT if remaining, else DSEP.
  - DSEP: dp_dsep_o=1 for 1 cycle -> MSG_WAIT.
  - MSG_WAIT: msg_ready_o=1. On handshake, dp_absorb_msg_o=1 -> MSG_OUT.
  - MSG_OUT: out_valid_o held until out_ready_i. Then -> MSG_PERM if remaining > 1, else FINAL_KEY.
  - MSG_PERM: PB_ROUNDS rounds, decrement -> MSG_WAIT. The last message block is never followed by MSG_PERM.
  - FINAL_KEY: dp_key_xor_o=1 -> FINAL_PERM.
  - FINAL_PERM: PA_ROUNDS rounds -> TAG.
  - TAG: tag_valid_o held until tag_ready_i -> DONE.
  - DONE: done_o=1 for 1 cycle -> IDLE.
- Round constant:
  - Round index i = 12 - nr + r, where nr is the run length and r = 0..nr-1.
  - dp_round_const_o = {4'(15-i), 4'(i)}.
  - PA runs: 0xF0 .. 0x4B. PB runs: 0x96 .. 0x4B.
  - dp_round_const_o is 0 when dp_round_en_o=0.
- Latency: start_i accepted in cycle 0 -> dp_init_o in cycle 1, rounds in cycles 2-13, key XOR in cycle 14, ad_ready_o or DSEP in cycle 15.
- Handshake rules: valid may arrive early or late; the controller waits indefinitely. out_valid_o and tag_valid_o stay stable until accepted.
- clear_i has priority over every transition. It forces IDLE next cycle with no done_o pulse. Datapath strobes are deasserted from that cycle.
- A new start_i is accepted in the IDLE cycle immediately following DONE.

Decomposition:
- ascon_pkg holds:
  - state enum (4-bit, encoding exported to state_o);
  - PA_ROUNDS/PB_ROUNDS defaults;
  - round-constant function rc(i).
- One sub-module, ascon_round_sched:
  - loads a run length (PA or PB), steps r each cycle, emits round_en, const and last_round;
  - reusable by a future hash-mode controller.

Test Plan:
- Reset: hold ARESETN low while start_i=1 -> all outputs 0, state_o=IDLE; release -> IDLE persists until start_i.
- ad=1, msg=1, all sinks ready:
  - dp_init_o in cycle 1;
  - constants 0xF0..0x4B in cycles 2-13;
  - ad_ready_o in cycle 15;
  - 6 rounds 0x96..0x4B;
  - dp_dsep_o once, exactly one out_valid_o beat, 12 final rounds, tag_valid_o, then done_o one cycle.
- ad=0, msg=3: no ad_ready_o ever; DSEP directly after INIT_KEY; three absorb/out beats with exactly two PB runs between them.
- Backpressure: out_ready_i low 5 cycles, tag_ready_i low 3 cycles -> out_valid_o/tag_valid_o stable throughout, no extra rounds.
- clear_i asserted in the middle of FINAL_PERM -> IDLE next cycle, busy_o=0, no done_o, no tag_valid_o. Async reset mid-AD_PERM -> same state.
- msg=0 treated as 1; start_i pulsed while busy -> ignored, block counts unchanged.
